// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result collector slice.
//   FFT_DATA_W / FFT_ADDR_W : default sample component width and address width
//   state_e                 : collector FSM states
//   bitrev()                : reverse the low w bits of a value (upper bits zero)
package fft_pkg;

  localparam int unsigned FFT_DATA_W = 8;
  localparam int unsigned FFT_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r[i] = v[w - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port
// with one cycle of latency. The read register only updates when re_i is
// high, so read data stays put while the consumer is stalled. No reset.
//   clk_i             : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read request
//   rdata_o           : read data, valid the cycle after re_i
module fft_result_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_result_collector.sv
// Collects one frame of FFT results while the core is busy, then drains it
// to a ready/valid consumer in natural or bit-reversed order.
//   clk, rst_n (async, active-low)
//   in_valid/in_addr/in_real/in_imag/in_busy : FFT core result stream
//   out_valid/out_ready/out_real/out_imag/out_index/out_last : drain stream
//   frame_done : one-cycle pulse when capture ends
//   count      : beats captured in current/last frame (saturates at 2**ADDR_W)
//   overrun    : sticky, a new frame started while draining; clear drops it
module fft_result_collector
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W      = FFT_DATA_W,
  parameter int unsigned ADDR_W      = FFT_ADDR_W,
  parameter int unsigned BIT_REVERSE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              in_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              frame_done,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clear
);

  localparam logic [ADDR_W:0] N   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              busy_q;
  logic              rise, fall;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   fetch_q, fetch_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_real_q, out_real_d;
  logic [DATA_W-1:0] out_imag_q, out_imag_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;

  logic                ram_we, ram_re;
  logic [ADDR_W-1:0]   ram_raddr;
  logic [2*DATA_W-1:0] ram_rdata;
  logic                adv, can_fetch;

  assign rise = in_busy & ~busy_q;
  assign fall = ~in_busy & busy_q;

  // Drain is a two-stage pipeline (RAM read, output register) sharing one
  // stall: both stages move only when the output register is empty or taken.
  assign adv       = ~out_valid_q | out_ready;
  assign can_fetch = (state_q == DRAIN) && (fetch_q < count_q);

  assign ram_raddr = (BIT_REVERSE != 0)
                   ? ADDR_W'(bitrev(32'(fetch_q[ADDR_W-1:0]), ADDR_W))
                   : fetch_q[ADDR_W-1:0];

  fft_result_ram #(
    .DATA_W(2 * DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(in_addr),
    .wdata_i({in_real, in_imag}),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fetch_d      = fetch_q;
    rd_vld_d     = rd_vld_q;
    rd_idx_d     = rd_idx_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_real_d   = out_real_q;
    out_imag_d   = out_imag_q;
    out_index_d  = out_index_q;
    frame_done_d = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          count_d = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (fall) begin
          frame_done_d = 1'b1;
          fetch_d      = '0;
          state_d      = (count_q != '0) ? DRAIN : IDLE;
        end else if (in_valid && in_busy) begin
          ram_we = 1'b1;
          if (count_q != N) begin
            count_d = count_q + ONE;
          end
        end
      end
      DRAIN: begin
        if (adv) begin
          out_valid_d = rd_vld_q;
          out_last_d  = rd_vld_q && ({1'b0, rd_idx_q} == (count_q - ONE));
          if (rd_vld_q) begin
            out_real_d  = ram_rdata[2*DATA_W-1:DATA_W];
            out_imag_d  = ram_rdata[DATA_W-1:0];
            out_index_d = rd_idx_q;
          end
          rd_vld_d = can_fetch;
          if (can_fetch) begin
            ram_re   = 1'b1;
            rd_idx_d = fetch_q[ADDR_W-1:0];
            fetch_d  = fetch_q + ONE;
          end
        end
        if (out_valid_q && out_ready && out_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clear) begin
      overrun_d = 1'b0;
    end
    if (rise && (state_q == DRAIN)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      count_q      <= '0;
      fetch_q      <= '0;
      rd_vld_q     <= 1'b0;
      rd_idx_q     <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_real_q   <= '0;
      out_imag_q   <= '0;
      out_index_q  <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= in_busy;
      count_q      <= count_d;
      fetch_q      <= fetch_d;
      rd_vld_q     <= rd_vld_d;
      rd_idx_q     <= rd_idx_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_real_q   <= out_real_d;
      out_imag_q   <= out_imag_d;
      out_index_q  <= out_index_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_real   = out_real_q;
  assign out_imag   = out_imag_q;
  assign out_index  = out_index_q;
  assign frame_done = frame_done_q;
  assign count      = count_q;
  assign overrun    = overrun_q;

endmodule
